// File: rtl/spu_event_fifo.sv
// spu_event_fifo
//   Captures every non-idle event from the SPU event port, tags it with a
//   free-running timestamp and queues it for a valid/ready trace sink.
//   A full queue drops the event, bumps a saturating drop counter and sets
//   a sticky overflow flag.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of queue, timestamp and drop state
//   e_id_i/e_info_i/s_id_i event port from spu_top (e_id_i == 0 means idle)
//   ev_valid_o/ev_ready_i  head-of-queue handshake (first-word-fall-through)
//   ev_id_o/ev_info_o/ev_sid_o/ev_ts_o  head entry, zero while empty
//   level_o                number of queued entries (0..DEPTH)
//   drop_cnt_o             saturating count of dropped events
//   overflow_o             sticky, set on the first drop
module spu_event_fifo #(
    parameter int NUM_EVENT       = 5,
    parameter int EVENT_INFO_BITS = 8,
    parameter int NUM_SOURCE      = 2,
    parameter int DEPTH           = 8,
    parameter int TS_WIDTH        = 32,
    parameter int DROP_CNT_WIDTH  = 16,
    localparam int EVENT_ID_BITS  = $clog2(NUM_EVENT + 1),
    localparam int SOURCE_ID_BITS = $clog2(NUM_SOURCE),
    localparam int LVL_W          = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [EVENT_ID_BITS-1:0]   e_id_i,
    input  logic [EVENT_INFO_BITS-1:0] e_info_i,
    input  logic [SOURCE_ID_BITS-1:0]  s_id_i,
    output logic                       ev_valid_o,
    input  logic                       ev_ready_i,
    output logic [EVENT_ID_BITS-1:0]   ev_id_o,
    output logic [EVENT_INFO_BITS-1:0] ev_info_o,
    output logic [SOURCE_ID_BITS-1:0]  ev_sid_o,
    output logic [TS_WIDTH-1:0]        ev_ts_o,
    output logic [LVL_W-1:0]           level_o,
    output logic [DROP_CNT_WIDTH-1:0]  drop_cnt_o,
    output logic                       overflow_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = EVENT_ID_BITS + EVENT_INFO_BITS + SOURCE_ID_BITS + TS_WIDTH;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + DROP_CNT_WIDTH'(1);
    endfunction

    logic [ENTRY_W-1:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]          level_q;
    logic [TS_WIDTH-1:0]       ts_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
    logic                      overflow_q;

    logic               push_req, pop, full, push_ok, drop, wr_en;
    logic [ENTRY_W-1:0] entry, head;

    // ---- capture / admission ----
    assign push_req = (e_id_i != '0);
    assign pop      = ev_valid_o & ev_ready_i;
    assign full     = (level_q == LVL_W'(DEPTH));
    // A pop in the same cycle frees the head slot, so a full queue still accepts.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign wr_en    = push_ok & ~clear_i;
    assign entry    = {e_id_i, e_info_i, s_id_i, ts_q};

    // ---- storage (payload is not reset; validity comes from level_q) ----
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry;
    end

    // ---- control state ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop);
            if (drop) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
                overflow_q <= 1'b1;
            end
        end
    end

    // ---- head output (first-word-fall-through, zeroed while empty) ----
    assign head       = mem_q[rd_ptr_q];
    assign ev_valid_o = (level_q != '0);
    assign ev_id_o    = ev_valid_o ? head[ENTRY_W-1 -: EVENT_ID_BITS] : '0;
    assign ev_info_o  = ev_valid_o ? head[SOURCE_ID_BITS+TS_WIDTH +: EVENT_INFO_BITS] : '0;
    assign ev_sid_o   = ev_valid_o ? head[TS_WIDTH +: SOURCE_ID_BITS] : '0;
    assign ev_ts_o    = ev_valid_o ? head[TS_WIDTH-1:0] : '0;
    assign level_o    = level_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_spu_event_fifo.sv
// Testbench for spu_event_fifo: two instances (default widths and a narrow
// 4-bit timestamp / 4-bit drop counter) share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_spu_event_fifo;

    localparam int DEPTH = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clear_i = 1'b0;
    logic [2:0] e_id_i = '0;
    logic [7:0] e_info_i = '0;
    logic       s_id_i = 1'b0;
    logic       ev_ready_i = 1'b0;

    logic        vb, vs;
    logic [2:0]  idb, ids;
    logic [7:0]  infob, infos;
    logic        sidb, sids;
    logic [31:0] tsb;
    logic [3:0]  tss;
    logic [3:0]  lvlb, lvls;
    logic [15:0] dropb;
    logic [3:0]  drops;
    logic        ovfb, ovfs;

    spu_event_fifo dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .e_id_i(e_id_i), .e_info_i(e_info_i), .s_id_i(s_id_i),
        .ev_valid_o(vb), .ev_ready_i(ev_ready_i),
        .ev_id_o(idb), .ev_info_o(infob), .ev_sid_o(sidb), .ev_ts_o(tsb),
        .level_o(lvlb), .drop_cnt_o(dropb), .overflow_o(ovfb)
    );

    spu_event_fifo #(.TS_WIDTH(4), .DROP_CNT_WIDTH(4)) dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .e_id_i(e_id_i), .e_info_i(e_info_i), .s_id_i(s_id_i),
        .ev_valid_o(vs), .ev_ready_i(ev_ready_i),
        .ev_id_o(ids), .ev_info_o(infos), .ev_sid_o(sids), .ev_ts_o(tss),
        .level_o(lvls), .drop_cnt_o(drops), .overflow_o(ovfs)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  id;
        logic [7:0]  info;
        logic        sid;
        logic [31:0] ts;
    } ev_t;

    ev_t         mq[$];
    logic [31:0] m_ts;
    int          m_drops;
    logic        m_ovf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts    = '0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // One rising edge of the reference behaviour, from the current inputs.
    task automatic model_edge();
        bit   pop;
        ev_t  e;
        if (clear_i) begin
            model_reset();
            return;
        end
        pop = (mq.size() != 0) && ev_ready_i;
        if (pop) void'(mq.pop_front());
        if (e_id_i != 0) begin
            if (mq.size() < DEPTH) begin
                e.id = e_id_i; e.info = e_info_i; e.sid = s_id_i; e.ts = m_ts;
                mq.push_back(e);
            end else begin
                m_drops++;
                m_ovf = 1'b1;
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic compare_all();
        ev_t h;
        bit  v;
        v = (mq.size() != 0);
        h = v ? mq[0] : '0;
        check("valid",    vb,    v);
        check("level",    lvlb,  mq.size());
        check("id",       idb,   h.id);
        check("info",     infob, h.info);
        check("sid",      sidb,  h.sid);
        check("ts",       tsb,   h.ts);
        check("drop",     dropb, (m_drops > 65535) ? 65535 : m_drops);
        check("ovf",      ovfb,  m_ovf);
        check("valid_s",  vs,    v);
        check("level_s",  lvls,  mq.size());
        check("id_s",     ids,   h.id);
        check("ts_s",     tss,   h.ts[3:0]);
        check("drop_s",   drops, (m_drops > 15) ? 15 : m_drops);
        check("ovf_s",    ovfs,  m_ovf);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [2:0] id, input logic rdy, input logic clr);
        e_id_i     = id;
        e_info_i   = 8'($urandom);
        s_id_i     = 1'($urandom);
        ev_ready_i = rdy;
        clear_i    = clr;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        rst_ni = 1'b1;

        // Single event at ts=5, then popped.
        repeat (5) begin drive(3'd0, 1'b0, 1'b0); step(); end
        e_id_i = 3'd2; e_info_i = 8'h14; s_id_i = 1'b1; ev_ready_i = 1'b0; clear_i = 1'b0;
        step();
        check("single_id",   idb,  3'd2);
        check("single_info", infob, 8'h14);
        check("single_sid",  sidb, 1'b1);
        check("single_ts",   tsb,  32'd5);
        check("single_lvl",  lvlb, 4'd1);
        drive(3'd0, 1'b1, 1'b0); step();
        check("single_gone", vb, 1'b0);

        // Fill past full with no sink.
        drive(3'd0, 1'b0, 1'b1); step();
        repeat (10) begin drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step(); end
        check("fill_lvl",  lvlb,  4'd8);
        check("fill_drop", dropb, 16'd2);
        check("fill_ovf",  ovfb,  1'b1);
        // Full with simultaneous push and pop.
        drive(3'd5, 1'b1, 1'b0); step();
        check("fullpp_lvl",  lvlb,  4'd8);
        check("fullpp_drop", dropb, 16'd2);
        repeat (8) begin drive(3'd0, 1'b1, 1'b0); step(); end
        check("drain_lvl", lvlb, 4'd0);

        // Backpressure stability with 3 entries.
        drive(3'd0, 1'b0, 1'b1); step();
        repeat (3) begin drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step(); end
        repeat (20) begin drive(3'd0, 1'b0, 1'b0); step(); end
        repeat (3) begin drive(3'd0, 1'b1, 1'b0); step(); end
        check("bp_empty", vb, 1'b0);

        // Clear with overflow set, 5 queued, and a concurrent event.
        drive(3'd0, 1'b0, 1'b1); step();
        repeat (9) begin drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step(); end
        repeat (3) begin drive(3'd0, 1'b1, 1'b0); step(); end
        check("pre_clr_lvl", lvlb, 4'd5);
        check("pre_clr_ovf", ovfb, 1'b1);
        drive(3'd4, 1'b1, 1'b1); step();
        check("clr_lvl",  lvlb,  4'd0);
        check("clr_drop", dropb, 16'd0);
        check("clr_ovf",  ovfb,  1'b0);
        drive(3'd1, 1'b0, 1'b0); step();
        check("clr_ts", tsb, 32'd0);

        // Drop counter saturation on the narrow instance.
        drive(3'd0, 1'b0, 1'b1); step();
        repeat (28) begin drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step(); end
        check("sat_s", drops, 4'd15);
        check("sat_b", dropb, 16'd20);
        drive(3'd6, 1'b0, 1'b0); step();
        check("sat_hold", drops, 4'd15);

        // Back-to-back events across the narrow timestamp wrap.
        drive(3'd0, 1'b1, 1'b1); step();
        repeat (40) begin drive(3'($urandom_range(1, 7)), 1'b1, 1'b0); step(); end

        // Randomized traffic with varying sink pressure and rare clears.
        for (int seg = 0; seg < 6; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 50 : 90);
            repeat (250) begin
                logic [2:0] id;
                id = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                drive(id, 1'($urandom_range(0, 99) < rdy_pct), 1'($urandom_range(0, 63) == 0));
                step();
            end
        end

        // Asynchronous reset in the middle of traffic.
        drive(3'd0, 1'b0, 1'b0);
        repeat (6) begin drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step(); end
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_ni = 1'b1;
        repeat (50) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom), 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spu_event_fifo.md
Name: spu_event_fifo

Overview:
- Downstream consumer of the SPU event port (e_id / e_info / s_id); sits directly behind spu_top.
- Each cycle with a non-zero event ID is captured, tagged with a free-running timestamp, and pushed into a FIFO.
- The FIFO drains through a valid/ready port to a trace sink or event-counter unit.
- A full FIFO drops the event, bumps a saturating drop counter and sets a sticky overflow flag.

Parameters:
- NUM_EVENT, 5, number of event types; EVENT_ID_BITS = $clog2(NUM_EVENT+1); ID 0 = no event.
- EVENT_INFO_BITS, 8, width of the event info field.
- NUM_SOURCE, 2, number of event sources; SOURCE_ID_BITS = $clog2(NUM_SOURCE); must be >= 2.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TS_WIDTH, 32, timestamp counter width.
- DROP_CNT_WIDTH, 16, drop counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush: empties the FIFO, zeroes the timestamp, drop count and overflow flag.
- e_id_i  in  EVENT_ID_BITS  event ID from SPU; 0 = idle.
- e_info_i  in  EVENT_INFO_BITS  event info.
- s_id_i  in  SOURCE_ID_BITS  source ID.
- ev_valid_o  out  1  head entry valid.
- ev_ready_i  in  1  sink accepts head entry.
- ev_id_o  out  EVENT_ID_BITS  head event ID.
- ev_info_o  out  EVENT_INFO_BITS  head info.
- ev_sid_o  out  SOURCE_ID_BITS  head source ID.
- ev_ts_o  out  TS_WIDTH  head timestamp.
- level_o  out  $clog2(DEPTH+1)  current fill level.
- drop_cnt_o  out  DROP_CNT_WIDTH  dropped events, saturating.
- overflow_o  out  1  sticky, set on the first drop.

Behaviour:
- Reset (async assert, release synchronised by the environment):
  - FIFO empty, so ev_valid_o=0 and level_o=0.
  - ts=0, drop_cnt_o=0, overflow_o=0.
  - Payload outputs are 0 while empty.
- Timestamp: ts increments by 1 every cycle, wraps 2^TS_WIDTH-1 -> 0. The stored ts is the counter value in the cycle the event is sampled.
- Capture:
  - push_req = (e_id_i != 0).
  - The whole tuple {e_id_i, e_info_i, s_id_i, ts} is sampled at that rising edge.
  - e_id_i values above NUM_EVENT are stored unmodified; no checking.
- Pop: pop = ev_valid_o && ev_ready_i.
- Push accepted when: level < DEPTH, or (level == DEPTH and pop in the same cycle).
  - Simultaneous push+pop at full is legal: level unchanged, no drop.
- Drop: push_req while full and no pop.
  - drop_cnt += 1, saturating at all-ones.
  - overflow_o <= 1 and stays 1 until clear_i.
  - FIFO contents are unchanged.
- Level arithmetic: level_o = level + push - pop, always 0..DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty is derived from the level counter.
- Latency:
  - An event sampled at edge N is visible on ev_valid_o/payload after edge N (one cycle).
  - There is no combinational bypass from e_*_i to ev_*_o, including when the FIFO is empty.
- Output is first-word-fall-through: payload = head entry whenever ev_valid_o=1.
- Output stability: while ev_valid_o=1 and ev_ready_i=0, all ev_*_o hold stable.
  - ev_valid_o never drops without a pop or clear_i.
- ev_ready_i while empty: no effect.
- clear_i (synchronous, highest priority):
  - Next cycle: level=0, ev_valid_o=0, ts=0, drop_cnt_o=0, overflow_o=0.
  - An event present in the clear cycle is discarded and not counted as a drop.
  - A pop in the clear cycle is ignored.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.

Test Plan:
- Single event: after reset, e_id_i=2, e_info_i=0x14, s_id_i=1 at cycle 5 (ts=5) -> cycle 6: ev_valid_o=1, id=2, info=0x14, sid=1, ts=5, level_o=1; ev_ready_i=1 -> cycle 7: ev_valid_o=0, level_o=0.
- Fill/overflow: DEPTH=8, ev_ready_i=0, 10 consecutive events -> level_o=8, drop_cnt_o=2, overflow_o=1; the entries read out afterwards are the first 8, in order, with consecutive ts.
- Full with simultaneous push+pop: FIFO full, ev_ready_i=1 and a new event in the same cycle -> level_o stays 8, drop_cnt_o unchanged, new entry appears last.
- Backpressure stability: hold ev_ready_i=0 for 20 cycles with 3 entries queued -> ev_*_o constant; then drain ev_ready_i=1 -> 3 pops in 3 cycles, order preserved.
- Clear: 5 entries queued, overflow_o=1, clear_i=1 with a concurrent event -> next cycle level_o=0, drop_cnt_o=0, overflow_o=0, ts=0; the concurrent event is absent.
- Saturation/wrap: DROP_CNT_WIDTH=4, TS_WIDTH=4, force 20 drops -> drop_cnt_o=15 and holds; an event at ts=15 followed by one on the next cycle -> stored ts 15 then 0.
